// File: rtl/text_fetch_pkg.sv
// Shared types, constants and address helpers for the character-mode fetch engine.
package text_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CODE,
      FONT,
      FLUSH
   } state_e;

   localparam int          C_COLS         = 32;
   localparam logic [15:0] C_TEXT_BASE    = 16'h6000;
   localparam logic [15:0] C_FONT_BASE    = 16'h5800;

   // Text page is 32 bytes per character row; the upper 5 line bits pick the row.
   function automatic logic [15:0] code_addr(input logic [15:0] base,
                                             input logic [4:0]  row_grp,
                                             input logic [4:0]  col);
      return base + {6'd0, row_grp, col};
   endfunction

   function automatic logic [15:0] font_addr(input logic [15:0] base,
                                             input logic [7:0]  code,
                                             input logic [2:0]  glyph_row);
      return base + {5'd0, code, glyph_row};
   endfunction

endpackage

// File: rtl/text_linebuf.sv
// Ping-pong line buffer: two 32-byte halves, synchronous write, asynchronous read.
module text_linebuf (
   input  logic       clock,
   input  logic       wr_en,
   input  logic [5:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [5:0] rd_addr,
   output logic [7:0] rd_data
);

   // Contents are deliberately left uninitialised; a reset does not clear the picture.
   logic [7:0] mem_q [64];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/text_fetch.sv
// Per-scanline fetch of 32 character codes and their font rows into a
// ping-pong buffer, plus the 1-bit pixel output for the display half.
module text_fetch
   import text_fetch_pkg::*;
#(
   parameter logic [15:0] P_text_base = C_TEXT_BASE,
   parameter logic [15:0] P_font_base = C_FONT_BASE
) (
   input  logic        I_clock,
   input  logic        I_reset,
   input  logic        I_line_start,
   input  logic [7:0]  I_line_num,
   input  logic [7:0]  I_pix_x,
   output logic        O_pixel,
   output logic [15:0] O_mem_addr,
   output logic        O_mem_rden,
   input  logic [7:0]  I_mem_data,
   output logic        O_busy,
   output logic        O_done,
   output logic        O_overrun
);

   state_e      state_q, state_d;
   logic [4:0]  col_q, col_d;
   logic        sel_q, sel_d;
   logic [7:0]  line_q, line_d;
   logic        rden_q, rden_d;
   logic        done_q, done_d;
   logic        overrun_q, overrun_d;
   logic        pixel_q, pixel_d;

   logic        busy;
   logic        wr_en;
   logic [4:0]  wr_col;
   logic [7:0]  rd_byte;
   logic [15:0] mem_addr;

   assign busy = (state_q != IDLE);

   // Next-state logic. A start pulse always wins; it drops a pending CODE write
   // but lets the final FLUSH write land so the abandoned half ends cleanly.
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      sel_d     = sel_q;
      line_d    = line_q;
      done_d    = 1'b0;
      overrun_d = 1'b0;
      wr_en     = 1'b0;
      wr_col    = col_q - 5'd1;

      case (state_q)
         CODE: begin
            wr_en   = (col_q != 5'd0);
            state_d = FONT;
         end
         FONT: begin
            if (col_q == 5'(C_COLS - 1)) begin
               state_d = FLUSH;
            end else begin
               col_d   = col_q + 5'd1;
               state_d = CODE;
            end
         end
         FLUSH: begin
            wr_en   = 1'b1;
            wr_col  = 5'(C_COLS - 1);
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: ;
      endcase

      if (I_line_start) begin
         if (state_q == CODE) begin
            wr_en = 1'b0;
         end
         overrun_d = busy;
         done_d    = 1'b0;
         sel_d     = ~sel_q;
         line_d    = I_line_num;
         col_d     = 5'd0;
         state_d   = CODE;
      end

      if (I_reset) begin
         wr_en = 1'b0;
      end

      rden_d  = (state_d == CODE) || (state_d == FONT);
      pixel_d = rd_byte[3'd7 - I_pix_x[2:0]];
   end

   // The font address depends on the code byte arriving this cycle, so the
   // address is decoded from the registered state rather than registered itself.
   always_comb begin
      mem_addr = 16'h0000;
      case (state_q)
         CODE:    mem_addr = code_addr(P_text_base, line_q[7:3], col_q);
         FONT:    mem_addr = font_addr(P_font_base, I_mem_data, line_q[2:0]);
         default: ;
      endcase
   end

   always_ff @(posedge I_clock) begin
      if (I_reset) begin
         state_q   <= IDLE;
         col_q     <= 5'd0;
         sel_q     <= 1'b0;
         line_q    <= 8'd0;
         rden_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         pixel_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         sel_q     <= sel_d;
         line_q    <= line_d;
         rden_q    <= rden_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         pixel_q   <= pixel_d;
      end
   end

   text_linebuf u_linebuf (
      .clock   (I_clock),
      .wr_en   (wr_en),
      .wr_addr ({~sel_q, wr_col}),
      .wr_data (I_mem_data),
      .rd_addr ({sel_q, I_pix_x[7:3]}),
      .rd_data (rd_byte)
   );

   assign O_pixel    = pixel_q;
   assign O_mem_addr = mem_addr;
   assign O_mem_rden = rden_q;
   assign O_busy     = busy;
   assign O_done     = done_q;
   assign O_overrun  = overrun_q;

endmodule

// File: tb/tb_text_fetch.sv
// Directed bench for text_fetch with a 1-cycle-latency memory model holding
// a synthetic text page (byte k = k[7:0]) and font (byte 8c+r = c^r).
module tb_text_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        line_start;
   logic [7:0]  line_num;
   logic [7:0]  pix_x;
   logic        pixel;
   logic [15:0] mem_addr;
   logic        mem_rden;
   logic [7:0]  mem_data = 8'h00;
   logic        busy;
   logic        done;
   logic        overrun;

   int total_checks = 0;
   int bad_checks   = 0;

   always #5 clk = ~clk;

   text_fetch dut (
      .I_clock      (clk),
      .I_reset      (reset),
      .I_line_start (line_start),
      .I_line_num   (line_num),
      .I_pix_x      (pix_x),
      .O_pixel      (pixel),
      .O_mem_addr   (mem_addr),
      .O_mem_rden   (mem_rden),
      .I_mem_data   (mem_data),
      .O_busy       (busy),
      .O_done       (done),
      .O_overrun    (overrun)
   );

   function automatic logic [7:0] mem_read(input logic [15:0] a);
      logic [15:0] off;
      if (a >= 16'h6000 && a < 16'h6400) return a[7:0];
      if (a >= 16'h5800 && a < 16'h6000) begin
         off = a - 16'h5800;
         return off[10:3] ^ {5'd0, off[2:0]};
      end
      return 8'h00;
   endfunction

   // Memory returns data the cycle after the read is issued.
   always @(posedge clk) begin
      if (mem_rden) mem_data <= mem_read(mem_addr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total_checks++;
      if (got !== exp) begin
         bad_checks++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Pulses start for one cycle; on return the bench sits in cycle 1 of the fetch.
   task automatic applyStimulus(input logic [7:0] line);
      line_start = 1'b1;
      line_num   = line;
      tick();
      line_start = 1'b0;
   endtask

   task automatic check_pixel_byte(input string tag, input logic [4:0] col, input logic [7:0] exp_byte);
      for (int i = 0; i < 8; i++) begin
         pix_x = {col, 3'(i)};
         tick();
         checkOutput(tag, {15'd0, pixel}, {15'd0, exp_byte[7-i]});
      end
   endtask

   initial begin
      logic [7:0]  exp_b;
      logic [7:0]  x;
      logic [15:0] exp_a;

      reset      = 1'b1;
      line_start = 1'b0;
      line_num   = 8'd0;
      pix_x      = 8'd0;
      tick_n(3);
      checkOutput("rst_pixel",   {15'd0, pixel},   16'd0);
      checkOutput("rst_addr",    mem_addr,         16'h0000);
      checkOutput("rst_rden",    {15'd0, mem_rden}, 16'd0);
      checkOutput("rst_busy",    {15'd0, busy},    16'd0);
      checkOutput("rst_done",    {15'd0, done},    16'd0);
      checkOutput("rst_overrun", {15'd0, overrun}, 16'd0);
      reset = 1'b0;
      tick();

      $display("[TB] line 0 fetch sequence");
      applyStimulus(8'h00);
      checkOutput("l0_overrun", {15'd0, overrun}, 16'd0);
      for (int cyc = 1; cyc <= 64; cyc++) begin
         exp_a = (cyc % 2 == 1) ? 16'h6000 + 16'((cyc - 1) / 2)
                                : 16'h5800 + 16'(8 * ((cyc - 1) / 2));
         checkOutput("l0_rden", {15'd0, mem_rden}, 16'd1);
         checkOutput("l0_addr", mem_addr, exp_a);
         checkOutput("l0_busy", {15'd0, busy}, 16'd1);
         tick();
      end
      checkOutput("l0_flush_rden", {15'd0, mem_rden}, 16'd0);
      checkOutput("l0_flush_busy", {15'd0, busy},     16'd1);
      checkOutput("l0_flush_done", {15'd0, done},     16'd0);
      tick();
      checkOutput("l0_done",      {15'd0, done}, 16'd1);
      checkOutput("l0_idle_busy", {15'd0, busy}, 16'd0);
      tick();
      checkOutput("l0_done_pulse", {15'd0, done}, 16'd0);

      $display("[TB] pixel sweep of line 0");
      applyStimulus(8'h01);
      for (int i = 0; i < 256; i++) begin
         x     = 8'(i);
         pix_x = x;
         tick();
         exp_b = {3'd0, x[7:3]};
         checkOutput("sweep_pixel", {15'd0, pixel}, {15'd0, exp_b[7 - x[2:0]]});
      end
      tick_n(4);

      $display("[TB] address arithmetic");
      applyStimulus(8'h2D);
      checkOutput("l2d_code0", mem_addr, 16'h60A0);
      tick();
      checkOutput("l2d_font0", mem_addr, 16'h5D05);
      tick_n(70);
      applyStimulus(8'h3D);
      tick_n(62);
      checkOutput("l3d_code31", mem_addr, 16'h60FF);
      tick();
      checkOutput("l3d_fontff", mem_addr, 16'h5FFD);
      tick_n(5);

      $display("[TB] overrun mid-fetch");
      applyStimulus(8'h08);
      checkOutput("ovr_first_code", mem_addr, 16'h6020);
      tick_n(29);
      checkOutput("ovr_busy30", {15'd0, busy}, 16'd1);
      applyStimulus(8'h10);
      checkOutput("ovr_pulse", {15'd0, overrun}, 16'd1);
      checkOutput("ovr_restart", mem_addr, 16'h6040);
      tick();
      checkOutput("ovr_pulse_end", {15'd0, overrun}, 16'd0);
      checkOutput("ovr_font0",     mem_addr, 16'h5A00);
      tick_n(63);
      checkOutput("ovr_done_early", {15'd0, done}, 16'd0);
      tick();
      checkOutput("ovr_done", {15'd0, done}, 16'd1);
      tick_n(2);
      applyStimulus(8'h00);
      check_pixel_byte("ovr_pix_c0",  5'd0,  8'h40);
      check_pixel_byte("ovr_pix_c5",  5'd5,  8'h45);
      check_pixel_byte("ovr_pix_c31", 5'd31, 8'h5F);
      tick_n(70);

      $display("[TB] reset mid-fetch");
      applyStimulus(8'h00);
      tick_n(39);
      reset = 1'b1;
      tick();
      checkOutput("rmid_rden", {15'd0, mem_rden}, 16'd0);
      checkOutput("rmid_busy", {15'd0, busy},     16'd0);
      checkOutput("rmid_addr", mem_addr,          16'h0000);
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         checkOutput("rmid_no_done", {15'd0, done},     16'd0);
         checkOutput("rmid_no_rd",   {15'd0, mem_rden}, 16'd0);
      end

      $display("[TB] start coincident with flush");
      applyStimulus(8'h28);
      tick_n(64);
      checkOutput("cf_flush_busy", {15'd0, busy},     16'd1);
      checkOutput("cf_flush_rden", {15'd0, mem_rden}, 16'd0);
      applyStimulus(8'h18);
      checkOutput("cf_no_done", {15'd0, done},    16'd0);
      checkOutput("cf_overrun", {15'd0, overrun}, 16'd1);
      checkOutput("cf_restart", mem_addr,         16'h6060);
      check_pixel_byte("cf_pix_c31", 5'd31, 8'hBF);
      check_pixel_byte("cf_pix_c0",  5'd0,  8'hA0);
      tick_n(49);
      checkOutput("cf_done", {15'd0, done}, 16'd1);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
